// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the AES block sequencer and its ciphertext collector.
package aes_seq_pkg;

   localparam int BLK_W  = 128;
   localparam int BYTE_W = 8;
   localparam int NBYTES = 16;

   typedef enum logic [2:0] {
      IDLE,
      CRST,
      LOAD,
      RUN,
      CAP,
      HOLD,
      ERR
   } seq_state_t;

endpackage

// File: rtl/aes_byte_collector.sv
// Left-shifting ciphertext capture register: each accepted byte enters at the LSB end,
// so the first captured byte ends up in the top byte once all 16 have arrived.
module aes_byte_collector
   import aes_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                shift_en,
   input  logic [BYTE_W-1:0]   din,
   output logic [BLK_W-1:0]    data,
   output logic [3:0]          cnt,
   output logic                full
);

   // full latches once the 16th byte lands and stays set until the next clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
         cnt  <= '0;
         full <= 1'b0;
      end else if (clr) begin
         data <= '0;
         cnt  <= '0;
         full <= 1'b0;
      end else if (shift_en) begin
         data <= {data[BLK_W-BYTE_W-1:0], din};
         cnt  <= cnt + 4'd1;
         full <= (cnt == 4'(NBYTES - 1));
      end
   end

endmodule

// File: rtl/aes_block_sequencer.sv
// Sequences one AES-128 block through the byte-serial core: core reset, 16-byte load,
// run with watchdog, 16-byte capture, then hold the result for the downstream consumer.
module aes_block_sequencer
   import aes_seq_pkg::*;
#(
   parameter int CORE_RST_CYC = 2,
   parameter int TIMEOUT_CYC  = 512
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BLK_W-1:0]    in_key,
   input  logic [BLK_W-1:0]    in_pt,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLK_W-1:0]    out_data,
   output logic                err,
   input  logic                clr_err,
   output logic                busy,
   output logic [15:0]         blk_cnt,
   output logic                core_rst,
   output logic [BYTE_W-1:0]   core_key,
   output logic [BYTE_W-1:0]   core_din,
   input  logic [BYTE_W-1:0]   core_dout,
   input  logic                core_dvld
);

   localparam logic [3:0]  CRST_LAST = 4'(CORE_RST_CYC - 1);
   localparam logic [3:0]  BYTE_LAST = 4'(NBYTES - 1);
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

   seq_state_t        state;
   seq_state_t        next_state;
   logic [BLK_W-1:0]  key_sr;
   logic [BLK_W-1:0]  pt_sr;
   logic [3:0]        crst_cnt;
   logic [3:0]        load_cnt;
   logic [15:0]       wdog;
   logic              col_clr;
   logic              col_shift;
   logic [3:0]        col_cnt;
   logic              col_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Per-state counters and the input shift registers; the watchdog is zeroed while loading
   // so it always starts from 0 on entry to RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_sr   <= '0;
         pt_sr    <= '0;
         crst_cnt <= '0;
         load_cnt <= '0;
         wdog     <= '0;
         blk_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               crst_cnt <= '0;
               if (in_valid) begin
                  key_sr <= in_key;
                  pt_sr  <= in_pt;
               end
            end
            CRST: begin
               crst_cnt <= crst_cnt + 4'd1;
               load_cnt <= '0;
            end
            LOAD: begin
               key_sr   <= {key_sr[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               pt_sr    <= {pt_sr[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               load_cnt <= load_cnt + 4'd1;
               wdog     <= '0;
            end
            RUN: wdog <= wdog + 16'd1;
            CAP: begin
               if (core_dvld && col_cnt == BYTE_LAST) blk_cnt <= blk_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // in_ready is masked by rst so the bus never sees a ready while the block is held in reset.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      core_rst   = 1'b1;
      col_clr    = 1'b0;
      col_shift  = 1'b0;
      busy       = 1'b1;
      err        = 1'b0;
      out_valid  = 1'b0;
      core_key   = '0;
      core_din   = '0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            in_ready = !rst;
            if (in_valid && !rst) begin
               col_clr    = 1'b1;
               next_state = CRST;
            end
         end
         CRST: begin
            if (crst_cnt == CRST_LAST) next_state = LOAD;
         end
         LOAD: begin
            core_rst = 1'b0;
            core_key = key_sr[BLK_W-1 -: BYTE_W];
            core_din = pt_sr[BLK_W-1 -: BYTE_W];
            if (load_cnt == BYTE_LAST) next_state = RUN;
         end
         RUN: begin
            core_rst = 1'b0;
            if (core_dvld) begin
               col_shift  = 1'b1;
               next_state = CAP;
            end else if (wdog == WDOG_LAST) begin
               next_state = ERR;
            end
         end
         CAP: begin
            core_rst = 1'b0;
            if (core_dvld) begin
               col_shift = 1'b1;
               if (col_cnt == BYTE_LAST) next_state = HOLD;
            end else begin
               next_state = ERR;
            end
         end
         HOLD: begin
            out_valid = col_full;
            if (out_ready) next_state = IDLE;
         end
         ERR: begin
            busy = 1'b0;
            err  = 1'b1;
            if (clr_err) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   aes_byte_collector u_collector (
      .clk      (clk),
      .rst      (rst),
      .clr      (col_clr),
      .shift_en (col_shift),
      .din      (core_dout),
      .data     (out_data),
      .cnt      (col_cnt),
      .full     (col_full)
   );

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: a stub core returns known FIPS-197 ciphertexts for the
// vectors it receives, and a queue holds the ciphertext each accepted request should yield.
module tb_aes_block_sequencer;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam int STUB_LAT = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_key = '0;
   logic [127:0]  in_pt = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  out_data;
   logic          err;
   logic          clr_err = 1'b0;
   logic          busy;
   logic [15:0]   blk_cnt;
   logic          core_rst;
   logic [7:0]    core_key;
   logic [7:0]    core_din;
   logic [7:0]    core_dout = '0;
   logic          core_dvld = 1'b0;

   logic [127:0]  exp_q[$];
   int            checks = 0;
   int            errors = 0;

   int            stub_mode = 0;
   logic [127:0]  rx_key = '0;
   logic [127:0]  rx_pt = '0;
   logic [127:0]  tx_ct = '0;
   int            rx_cnt = 0;
   int            lat_cnt = 0;
   int            tx_idx = 0;

   aes_block_sequencer #(.CORE_RST_CYC(2), .TIMEOUT_CYC(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_pt     (in_pt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .clr_err   (clr_err),
      .busy      (busy),
      .blk_cnt   (blk_cnt),
      .core_rst  (core_rst),
      .core_key  (core_key),
      .core_din  (core_din),
      .core_dout (core_dout),
      .core_dvld (core_dvld)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] stub_ct(input logic [127:0] k, input logic [127:0] p);
      if (k == C1_KEY && p == C1_PT) return C1_CT;
      if (k == B_KEY && p == B_PT)   return B_CT;
      return k ^ p ^ {4{32'hdeadbeef}};
   endfunction

   // Stub core works on the falling edge; mode 0 normal, 1 never valid, 2 drops valid after 7 bytes.
   always @(negedge clk) begin
      if (rst || core_rst) begin
         rx_cnt = 0; lat_cnt = 0; tx_idx = 0; core_dvld = 1'b0; core_dout = '0;
      end else if (rx_cnt < 16) begin
         rx_key = {rx_key[119:0], core_key};
         rx_pt  = {rx_pt[119:0], core_din};
         rx_cnt++;
         if (rx_cnt == 16) tx_ct = stub_ct(rx_key, rx_pt);
      end else if (lat_cnt < STUB_LAT) begin
         lat_cnt++;
      end else if (stub_mode != 1 && tx_idx < 16 && !(stub_mode == 2 && tx_idx == 7)) begin
         core_dvld = 1'b1;
         core_dout = tx_ct[127 - 8*tx_idx -: 8];
         tx_idx++;
      end else begin
         core_dvld = 1'b0;
         core_dout = '0;
      end
   end

   task automatic send(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct,
                       input bit push, output bit ok);
      ok = 1'b0;
      in_key = k; in_pt = p; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (ok && push) exp_q.push_back(ct);
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, core_rst, out_valid, err, busy} !== 5'b01000) begin
         errors++; $display("[TB] FAIL reset_ctrl: got %b expected 01000", {in_ready, core_rst, out_valid, err, busy});
      end
      checks++;
      if (out_data !== '0 || blk_cnt !== 16'd0 || core_key !== 8'd0 || core_din !== 8'd0) begin
         errors++; $display("[TB] FAIL reset_data: got data=%h blk=%0d key=%h din=%h expected zeros", out_data, blk_cnt, core_key, core_din);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_release: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
   endtask

   task automatic test_fips_c1(input logic [15:0] exp_blk);
      bit ok;
      logic [127:0] exp;
      send(C1_KEY, C1_PT, C1_CT, 1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL c1_accept: got timeout expected handshake"); end
      @(posedge clk); #1;
      checks++;
      if (core_rst !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL c1_crst: got core_rst=%b busy=%b expected 1 1", core_rst, busy);
      end
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (core_rst !== 1'b0 || core_key !== 8'h01 || core_din !== 8'h11) begin
         errors++; $display("[TB] FAIL c1_load_byte1: got rst=%b key=%h din=%h expected 0 01 11", core_rst, core_key, core_din);
      end
      wait_out(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL c1_out_timeout: got no out_valid expected out_valid"); end
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("[TB] FAIL c1_data: got %h expected %h", out_data, exp); end
      checks++;
      if (blk_cnt !== exp_blk) begin errors++; $display("[TB] FAIL c1_blk_cnt: got %0d expected %0d", blk_cnt, exp_blk); end
      checks++;
      if (rx_key !== C1_KEY || rx_pt !== C1_PT) begin
         errors++; $display("[TB] FAIL c1_core_rx: got key=%h pt=%h expected %h %h", rx_key, rx_pt, C1_KEY, C1_PT);
      end
      checks++;
      if (core_rst !== 1'b1 || core_key !== 8'd0 || in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL c1_hold_ctrl: got rst=%b key=%h in_ready=%b expected 1 00 0", core_rst, core_key, in_ready);
      end
      take_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL c1_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_fips_b();
      bit ok;
      logic [127:0] exp;
      send(B_KEY, B_PT, B_CT, 1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL b_accept: got timeout expected handshake"); end
      wait_out(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL b_out_timeout: got no out_valid expected out_valid"); end
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("[TB] FAIL b_data: got %h expected %h", out_data, exp); end
      checks++;
      if (blk_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b_blk_cnt: got %0d expected 2", blk_cnt); end
      take_out();
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [127:0] exp;
      int bad;
      send(C1_KEY, C1_PT, C1_CT, 1'b1, ok);
      wait_out(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp_out_timeout: got no out_valid expected out_valid"); end
      exp = exp_q.pop_front();
      in_key = B_KEY; in_pt = B_PT; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles (data=%h in_ready=%b) expected 0", bad, out_data, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || blk_cnt !== 16'd3) begin
         errors++; $display("[TB] FAIL bp_idle: got in_ready=%b blk=%0d expected 1 3", in_ready, blk_cnt);
      end
      @(posedge clk); #1;
      exp_q.push_back(B_CT);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_next_accept: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
      end
      wait_out(ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || out_data !== exp) begin errors++; $display("[TB] FAIL bp_second_data: got %h expected %h", out_data, exp); end
      checks++;
      if (blk_cnt !== 16'd4) begin errors++; $display("[TB] FAIL bp_blk_cnt: got %0d expected 4", blk_cnt); end
      take_out();
   endtask

   task automatic test_watchdog();
      bit ok;
      stub_mode = 1;
      send(C1_KEY, C1_PT, C1_CT, 1'b0, ok);
      repeat (81) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL wd_early: got err=%b busy=%b expected 0 1", err, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({err, busy, in_ready, out_valid, core_rst} !== 5'b10001) begin
         errors++; $display("[TB] FAIL wd_err: got %b expected 10001", {err, busy, in_ready, out_valid, core_rst});
      end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      checks++;
      if (err !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== 16'd4) begin
         errors++; $display("[TB] FAIL wd_clear: got err=%b in_ready=%b blk=%0d expected 0 1 4", err, in_ready, blk_cnt);
      end
      stub_mode = 0;
   endtask

   task automatic test_protocol_break();
      bit ok;
      bit seen_valid;
      stub_mode = 2;
      seen_valid = 1'b0;
      ok = 1'b0;
      send(C1_KEY, C1_PT, C1_CT, 1'b0, ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) seen_valid = 1'b1;
         if (err) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL pb_err: got err=%b expected 1", err); end
      checks++;
      if (seen_valid || blk_cnt !== 16'd4) begin
         errors++; $display("[TB] FAIL pb_no_output: got seen_valid=%b blk=%0d expected 0 4", seen_valid, blk_cnt);
      end
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      stub_mode = 0;
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      send(C1_KEY, C1_PT, C1_CT, 1'b0, ok);
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if (core_key !== 8'h05 || core_din !== 8'h55) begin
         errors++; $display("[TB] FAIL rl_byte5: got key=%h din=%h expected 05 55", core_key, core_din);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, core_rst, out_valid, err, busy} !== 5'b01000 || out_data !== '0 ||
          blk_cnt !== 16'd0 || core_key !== 8'd0 || core_din !== 8'd0) begin
         errors++; $display("[TB] FAIL rl_reset_vals: got ctrl=%b blk=%0d key=%h din=%h expected 01000 0 00 00",
                            {in_ready, core_rst, out_valid, err, busy}, blk_cnt, core_key, core_din);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      $display("[TB] starting aes_block_sequencer bench");
      test_reset();
      test_fips_c1(16'd1);
      test_fips_b();
      test_back_to_back();
      test_watchdog();
      test_protocol_break();
      test_reset_mid_load();
      test_fips_c1(16'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got hang expected completion");
      $fatal(1, "[TB] bench did not finish");
   end

endmodule
